// File: rtl/esp_resp_parser.sv
// esp_resp_parser
// ---------------------------------------------------------------------------
// Receive side of the ESP32 AT-command link. Bytes from the UART receiver are
// split into CR/LF terminated lines; each completed line is classified against
// the fixed AT result keywords. One result code is returned per armed command
// over a valid/ready handshake. A countdown timer turns a silent module into a
// TIMEOUT result.
//
// Handshakes (both directions): a transfer happens on a rising clk edge where
// valid && ready are both high. Once res_valid is raised, res_code and
// res_valid stay stable until that transfer; rx_ready depends on state only.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx_data    received byte            rx_valid  byte valid
//   rx_ready   parser can accept a byte (low only while a result is pending)
//   arm        one-cycle pulse: a command was sent, wait for its result
//   res_code   1=OK 2=ERROR 3=FAIL 4=READY 5=PROMPT 6=SEND_OK 7=TIMEOUT 0=none
//   res_valid  res_code valid           res_ready controller consumes result
//   busy       high while waiting for a result
//   line_cnt   count of non-empty completed lines (wraps)
//   dbg_state  current FSM state (0=IDLE 1=WAIT 2=DONE)
// ---------------------------------------------------------------------------
module esp_resp_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned MAX_LINE       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       arm,
  output logic [2:0] res_code,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic [7:0] line_cnt,
  output logic [1:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(MAX_LINE + 1);
  localparam int NKW = 5;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_PROMPT = 8'h3E;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_PROMPT  = 3'd5;
  localparam logic [2:0] CODE_TIMEOUT = 3'd7;

  // Keywords left-aligned in 7 bytes; byte i sits at bits [55-8i -: 8].
  localparam logic [55:0] KW_TXT [NKW] = '{
    {"OK",    40'h0},
    {"ERROR", 16'h0},
    {"FAIL",  24'h0},
    {"ready", 16'h0},
    "SEND OK"
  };
  localparam int unsigned KW_LEN  [NKW] = '{2, 5, 4, 5, 7};
  localparam logic [2:0]  KW_CODE [NKW] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [NKW-1:0]   flags_q;
  logic [TW-1:0]    timer_q;
  logic [7:0]       line_cnt_q;
  logic [2:0]       res_code_q;
  logic             res_valid_q;

  // Next-state values for the line matcher when a plain character arrives.
  logic [IW-1:0]    idx_d;
  logic [NKW-1:0]   flags_d;
  // Keyword match for the line that a LF would complete right now.
  logic             kw_hit;
  logic [2:0]       kw_code;

  always_comb begin
    flags_d = flags_q;
    kw_hit  = 1'b0;
    kw_code = CODE_NONE;
    for (int k = 0; k < NKW; k++) begin
      // A character past the keyword's end, or a differing one, rules it out.
      if (32'(idx_q) >= KW_LEN[k]) begin
        flags_d[k] = 1'b0;
      end else if (rx_data != KW_TXT[k][55 - 8*32'(idx_q) -: 8]) begin
        flags_d[k] = 1'b0;
      end
      if (flags_q[k] && (32'(idx_q) == KW_LEN[k])) begin
        kw_hit  = 1'b1;
        kw_code = KW_CODE[k];
      end
    end
    // Saturate so an over-long line cannot wrap back to a matching index.
    idx_d = (32'(idx_q) < MAX_LINE) ? idx_q + IW'(1) : idx_q;
  end

  logic byte_lf, byte_cr, byte_prompt;
  logic line_done, prompt_done;

  assign byte_lf     = rx_valid && (rx_data == CH_LF);
  assign byte_cr     = rx_valid && (rx_data == CH_CR);
  assign byte_prompt = rx_valid && (rx_data == CH_PROMPT) && (idx_q == '0);
  assign line_done   = byte_lf && (idx_q != '0) && kw_hit;
  assign prompt_done = byte_prompt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      flags_q     <= '1;
      timer_q     <= '0;
      line_cnt_q  <= '0;
      res_code_q  <= CODE_NONE;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Bytes are accepted and dropped here.
          if (arm) begin
            state_q <= ST_WAIT;
            idx_q   <= '0;
            flags_q <= '1;
            timer_q <= TW'(TIMEOUT_CYCLES);
          end
        end

        ST_WAIT: begin
          if (arm) begin
            // Restart: any byte in this cycle and the partial line are lost.
            idx_q   <= '0;
            flags_q <= '1;
            timer_q <= TW'(TIMEOUT_CYCLES);
          end else begin
            timer_q <= timer_q - TW'(1);
            if (rx_valid && !byte_cr && !byte_prompt) begin
              if (byte_lf) begin
                if (idx_q != '0) begin
                  line_cnt_q <= line_cnt_q + 8'd1;
                  idx_q      <= '0;
                  flags_q    <= '1;
                end
              end else begin
                idx_q   <= idx_d;
                flags_q <= flags_d;
              end
            end
            // A completed match outranks a timer expiring in the same cycle.
            if (line_done) begin
              state_q     <= ST_DONE;
              res_code_q  <= kw_code;
              res_valid_q <= 1'b1;
            end else if (prompt_done) begin
              state_q     <= ST_DONE;
              res_code_q  <= CODE_PROMPT;
              res_valid_q <= 1'b1;
            end else if (timer_q == TW'(1)) begin
              state_q     <= ST_DONE;
              res_code_q  <= CODE_TIMEOUT;
              res_valid_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_code_q  <= CODE_NONE;
            res_valid_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready  = (state_q != ST_DONE);
  assign busy      = (state_q == ST_WAIT);
  assign res_code  = res_code_q;
  assign res_valid = res_valid_q;
  assign line_cnt  = line_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_esp_resp_parser.sv
// Bench for esp_resp_parser. In message strings '^' stands for CR (0x0D)
// and '~' for LF (0x0A). Each expected result {res_code, line_cnt} is queued
// when its command is armed and compared when the controller side consumes it.
module tb_esp_resp_parser;

  localparam int TO = 1000;
  localparam int W  = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       arm;
  logic [2:0] res_code;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic [7:0] line_cnt;
  logic [1:0] dbg_state;

  esp_resp_parser #(.TIMEOUT_CYCLES(TO), .MAX_LINE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .arm       (arm),
    .res_code  (res_code),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .line_cnt  (line_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   sb_exp;
  logic [7:0]     model_lines;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Result consumed on the next rising edge: compare against the queue head.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got code %0d lines %0d expected none", res_code, line_cnt);
      end else begin
        sb_exp = exp_q.pop_front();
        check("result{code,lines}", {21'd0, res_code, line_cnt}, {21'd0, sb_exp});
      end
    end
  end

  task automatic expect_result(input logic [2:0] code, input int lines);
    model_lines = model_lines + 8'(lines);
    exp_q.push_back({code, model_lines});
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] map_ch(input byte c);
    if (c == "^") return 8'h0D;
    if (c == "~") return 8'h0A;
    return 8'(c);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_wait: got rx_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit quiet);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(map_ch(s[i]));
      if (quiet && i < s.len() - 1) check("no_early_result", res_valid, 0);
    end
  endtask

  task automatic do_arm();
    @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || res_valid) && t < 3000) begin
      t++;
      @(negedge clk);
    end
    check("idle_reached{busy,valid}", {busy, res_valid}, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string      msg;
    logic [2:0] code;
    int         lines;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"AT^~^~OK^~",              3'd1, 2};
    vecs[1]  = '{"ERRORX^~ERROR^~",         3'd2, 2};
    vecs[2]  = '{"AT+CIPSEND=4^~>",         3'd5, 1};
    vecs[3]  = '{"FAIL^~",                  3'd3, 1};
    vecs[4]  = '{"ready^~",                 3'd4, 1};
    vecs[5]  = '{"SEND OK^~",               3'd6, 1};
    vecs[6]  = '{"OKK^~OK^~",               3'd1, 2};
    vecs[7]  = '{"SEND^~ O^~ERROR^~",       3'd2, 3};
    vecs[8]  = '{"ok^~OK^~",                3'd1, 2};
    vecs[9]  = '{"A>^~OK^~",                3'd1, 2};
    vecs[10] = '{"OKxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxx^~ready^~", 3'd4, 2};
    vecs[11] = '{"^~^~^^OK^~",              3'd1, 1};
    vecs[12] = '{"OK^^^~",                  3'd1, 1};
    vecs[13] = '{"ERR^OR^~",                3'd2, 1};

    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; arm = 1'b0; res_ready = 1'b1;
    model_lines = 8'd0;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_code",  res_code, 0);
    check("rst_busy",      busy, 0);
    check("rst_line_cnt",  line_cnt, 0);
    check("rst_rx_ready",  rx_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;

    // ---- bytes in IDLE without arm ----
    @(posedge clk);
    #1;
    send_str("OK^~", 0);
    repeat (3) @(negedge clk);
    check("idle_no_result", res_valid, 0);
    check("idle_line_cnt", line_cnt, 0);
    check("idle_busy", busy, 0);

    // ---- table-driven commands ----
    for (int i = 0; i < 14; i++) begin
      expect_result(vecs[i].code, vecs[i].lines);
      do_arm();
      @(negedge clk);
      check("busy_in_wait", busy, 1);
      @(posedge clk);
      #1;
      send_str(vecs[i].msg, 1);
      check("valid_after_term", res_valid, 1);
      check("code_after_term", res_code, vecs[i].code);
      wait_idle();
    end

    // ---- timeout with no bytes: valid exactly TO cycles after arm ----
    expect_result(3'd7, 0);
    do_arm();
    repeat (TO) @(negedge clk);
    check("timeout_not_early", res_valid, 0);
    @(negedge clk);
    check("timeout_valid", res_valid, 1);
    check("timeout_code", res_code, 7);
    wait_idle();

    // ---- LF accepted on the expiry edge: match wins ----
    expect_result(3'd1, 1);
    do_arm();
    repeat (TO - 3) @(posedge clk);
    #1;
    send_byte("O");
    send_byte("K");
    send_byte(8'h0A);
    check("race_valid", res_valid, 1);
    check("race_code", res_code, 1);
    wait_idle();

    // ---- re-arm in WAIT discards the partial line ----
    expect_result(3'd1, 2);
    do_arm();
    send_str("ER", 0);
    do_arm();
    send_str("ROR~OK~", 1);
    check("rearm_code", res_code, 1);
    wait_idle();

    // ---- arm and byte in the same cycle: byte dropped ----
    expect_result(3'd1, 1);
    do_arm();
    send_str("OK", 0);
    arm = 1'b1; rx_data = "X"; rx_valid = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0; rx_valid = 1'b0;
    send_str("OK~", 1);
    check("arm_byte_code", res_code, 1);
    wait_idle();

    // ---- result held while res_ready low; arm in DONE ignored ----
    res_ready = 1'b0;
    expect_result(3'd1, 1);
    do_arm();
    send_str("OK^~", 1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 10) arm = 1'b1;
      if (c == 11) arm = 1'b0;
      check("hold_valid", res_valid, 1);
      check("hold_code", res_code, 1);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_code", res_code, 0);
    check("release_busy", busy, 0);

    // ---- prompt, then backpressure on a byte offered in DONE ----
    expect_result(3'd5, 1);
    do_arm();
    send_str("AT+CIPSEND=4^~>", 1);
    check("prompt_code", res_code, 5);
    rx_data = "X"; rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("done_rx_ready", rx_ready, 0);
      check("done_valid", res_valid, 1);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("after_done_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    check("idle_byte_no_result", res_valid, 0);
    check("idle_byte_lines", line_cnt, model_lines);
    res_ready = 1'b1;

    // ---- asynchronous reset mid-line ----
    do_arm();
    send_str("rea", 0);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_line_cnt", line_cnt, 0);
    check("arst_rx_ready", rx_ready, 1);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_code", res_code, 0);
    model_lines = 8'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    expect_result(3'd4, 1);
    do_arm();
    send_str("ready^~", 1);
    check("post_rst_code", res_code, 4);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
